// File: rtl/npu_result_packer.sv
// npu_result_packer: packs pairs of 16-bit TPU results into 32-bit words,
// closes a tile on the rising edge of the all-lanes load_end condition,
// buffers the words in a small FIFO and streams them out on valid/ready.
module npu_result_packer #(
    parameter int DEPTH = 8,
    parameter int CW    = 8
) (
    input  logic                     caravel_wb_clk_i,
    input  logic                     caravel_wb_rst_ni,
    input  logic [15:0]              out1,
    input  logic                     en,
    input  logic [3:0]               load_end,
    output logic [31:0]              m_data,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            tile_cnt,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic {
        EMPTY,
        HALF
    } state_t;

    state_t         state;
    logic [15:0]    held;
    logic           prev_all;
    logic           tile_end;

    logic           push;
    logic [32:0]    push_word;
    logic           pop;
    logic           accept;

    logic [32:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [32:0]    head;

    assign tile_end = (&load_end) & ~prev_all;

    // Decide whether the current cycle completes a word and what it holds.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        unique case (state)
            EMPTY: begin
                if (en && tile_end) begin
                    push      = 1'b1;
                    push_word = {1'b1, 16'h0000, out1};
                end
            end
            HALF: begin
                if (en) begin
                    push      = 1'b1;
                    push_word = {tile_end, out1, held};
                end else if (tile_end) begin
                    push      = 1'b1;
                    push_word = {1'b1, 16'h0000, held};
                end
            end
            default: ;
        endcase
    end

    assign pop     = m_valid & m_ready;
    // A full FIFO can still take a word when the head leaves on the same edge.
    assign accept  = push & ((level != FULL) | pop);
    assign head    = mem[rd_ptr];
    assign m_data  = head[31:0];
    assign m_last  = head[32];
    assign m_valid = (level != '0);

    // Packer state; advances even when the completed word is dropped.
    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_ni) begin
        if (!caravel_wb_rst_ni) begin
            state <= EMPTY;
            held  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (en && !tile_end) begin
                        held  <= out1;
                        state <= HALF;
                    end
                end
                HALF: begin
                    if (en || tile_end) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Tile edge detection and tile counting.
    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_ni) begin
        if (!caravel_wb_rst_ni) begin
            prev_all <= 1'b0;
            tile_cnt <= '0;
        end else begin
            prev_all <= &load_end;
            if (tile_end) begin
                tile_cnt <= tile_cnt + 1'b1;
            end
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_ni) begin
        if (!caravel_wb_rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !accept) begin
                level <= level - 1'b1;
            end
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_ni) begin
        if (!caravel_wb_rst_ni) begin
            overflow <= 1'b0;
        end else if (push && !accept) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_npu_result_packer.sv
// Scoreboard bench for npu_result_packer: directed stimulus pushes the
// hand-computed words into a queue; a monitor pops and compares on handshake.
module tb_npu_result_packer;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic               clk;
    logic               rst_n;
    logic [15:0]        out1;
    logic               en;
    logic [3:0]         load_end;
    logic [31:0]        m_data;
    logic               m_last;
    logic               m_valid;
    logic               m_ready;
    logic [$clog2(DEPTH):0] level;
    logic [CW-1:0]      tile_cnt;
    logic               overflow;
    logic               clr_ovf;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    npu_result_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .caravel_wb_clk_i  (clk),
        .caravel_wb_rst_ni (rst_n),
        .out1              (out1),
        .en                (en),
        .load_end          (load_end),
        .m_data            (m_data),
        .m_last            (m_last),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .level             (level),
        .tile_cnt          (tile_cnt),
        .overflow          (overflow),
        .clr_ovf           (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [15:0] d);
        en   = 1'b1;
        out1 = d;
        step();
        en   = 1'b0;
    endtask

    // Issues nwords pairs; only the first nexp are expected to reach the output.
    task automatic fill(input logic [15:0] base, input int nwords, input int nexp);
        logic [15:0] lo;
        logic [15:0] hi;
        for (int i = 1; i <= nwords; i++) begin
            lo = base + 16'(2 * i - 1);
            hi = base + 16'(2 * i);
            if (i <= nexp) exp_q.push_back({1'b0, hi, lo});
            sample(lo);
            sample(hi);
        end
    endtask

    // Monitor: handshake seen mid-cycle is the one taken at the next edge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {31'h0, m_last, m_data}, 64'h1_dead_beef);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("word_data", 64'(m_data), 64'(e[31:0]));
                chk("word_last", 64'(m_last), 64'(e[32]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        out1     = '0;
        load_end = '0;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;
        step();
        step();
        chk("rst_m_valid",  64'(m_valid),  64'd0);
        chk("rst_m_data",   64'(m_data),   64'd0);
        chk("rst_m_last",   64'(m_last),   64'd0);
        chk("rst_level",    64'(level),    64'd0);
        chk("rst_tile_cnt", 64'(tile_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        step();

        // Pair packing
        m_ready = 1'b1;
        exp_q.push_back({1'b0, 32'h2222_1111});
        sample(16'h1111);
        sample(16'h2222);
        chk("pair_valid_latency", 64'(m_valid), 64'd1);
        step();
        chk("pair_level_back_0", 64'(level), 64'd0);

        // Odd flush on tile end, held 4'hF counts once
        sample(16'hABCD);
        exp_q.push_back({1'b1, 32'h0000_ABCD});
        load_end = 4'hF;
        step();
        chk("flush_tile_cnt", 64'(tile_cnt), 64'd1);
        for (int i = 0; i < 5; i++) step();
        chk("held_tile_no_recount", 64'(tile_cnt), 64'd1);
        load_end = 4'h0;
        step();

        // Tile end coincident with the second sample
        exp_q.push_back({1'b1, 32'h0002_0001});
        sample(16'h0001);
        en = 1'b1; out1 = 16'h0002; load_end = 4'hF;
        step();
        en = 1'b0; load_end = 4'h0;
        step();
        chk("coincident_tile_cnt", 64'(tile_cnt), 64'd2);

        // Tile end with nothing held: no word, count still advances
        load_end = 4'hF;
        step();
        load_end = 4'h0;
        step();
        chk("empty_tile_cnt", 64'(tile_cnt), 64'd3);
        chk("empty_tile_no_word", 64'(level), 64'd0);

        // Single sample coincident with tile end from EMPTY
        exp_q.push_back({1'b1, 32'h0000_7777});
        en = 1'b1; out1 = 16'h7777; load_end = 4'hF;
        step();
        en = 1'b0; load_end = 4'h0;
        step();
        chk("single_tile_cnt", 64'(tile_cnt), 64'd4);

        // Backpressure and overflow
        m_ready = 1'b0;
        step();
        chk("bp_start_level", 64'(level), 64'd0);
        fill(16'h1000, 9, 8);
        chk("full_level", 64'(level), 64'd8);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_head_data", 64'(m_data), 64'h1002_1001);
        step();
        chk("stall_head_stable", 64'(m_data), 64'h1002_1001);
        chk("stall_last_stable", 64'(m_last), 64'd0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", 64'(overflow), 64'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("drain_no_gaps", 64'(level), 64'd0);

        // Full with simultaneous pop
        m_ready = 1'b0;
        fill(16'h2000, 8, 8);
        chk("refill_level", 64'(level), 64'd8);
        sample(16'h2011);
        exp_q.push_back({1'b0, 32'h2012_2011});
        m_ready = 1'b1; en = 1'b1; out1 = 16'h2012;
        step();
        en = 1'b0;
        chk("full_pop_level", 64'(level), 64'd8);
        chk("full_pop_no_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 8; i++) step();
        chk("full_pop_drain", 64'(level), 64'd0);

        // Reset mid-operation
        m_ready = 1'b0;
        fill(16'h3000, 3, 0);
        sample(16'h3007);
        chk("pre_reset_level", 64'(level), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(m_valid), 64'd0);
        chk("async_rst_level", 64'(level), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        m_ready = 1'b1;
        exp_q.push_back({1'b0, 32'h6666_5555});
        sample(16'h5555);
        sample(16'h6666);
        step();
        step();
        chk("post_reset_level", 64'(level), 64'd0);

        // Bounded wait for the scoreboard to empty
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
